mem_port_arbiter: RTL and testbench

//  Shares the single-port synchronous data memory between two requesters: the

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch path (F, read-only) and the load/store path (D).
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req_f,
    input  logic [ADDR_W-1:0] addr_f,
    input  logic              req_d,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] wdata_d,
    input  logic              we_d,
    output logic              gnt_f,
    output logic              gnt_d,
    output logic              done_f,
    output logic              done_d,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a requester holds req and its payload until it sees its gnt
    // pulse at a rising edge; a req still high the cycle after gnt is a new one.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;     // 1 = D has priority
    logic              owner_q, owner_d;   // 1 = access in flight belongs to D
    logic              store_q, store_d;
    logic              gntf_q, gntf_d;
    logic              gntd_q, gntd_d;
    logic              donef_q, donef_d;
    logic              doned_q, doned_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mdin_q, mdin_d;
    logic              mwe_q, mwe_d;

    logic any_req;
    logic win_ld;
    logic start;

    assign any_req = req_f | req_d;
    assign win_ld  = req_d & (~req_f | prio_q);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        store_d = store_q;
        gntf_d  = 1'b0;
        gntd_d  = 1'b0;
        donef_d = 1'b0;
        doned_d = 1'b0;
        rdata_d = rdata_q;
        maddr_d = maddr_q;
        mdin_d  = mdin_q;
        mwe_d   = mwe_q;
        start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                start = any_req;
            end
            S_ACCESS: begin
                mwe_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!store_q) rdata_d = mem_q;
                donef_d = ~owner_q;
                doned_d = owner_q;
                state_d = S_IDLE;
                start   = any_req;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared by IDLE and back-to-back RESP: grant flips priority.
        if (start) begin
            state_d = S_ACCESS;
            owner_d = win_ld;
            prio_d  = ~win_ld;
            store_d = win_ld & we_d;
            if (win_ld) begin
                gntd_d  = 1'b1;
                maddr_d = addr_d;
                mdin_d  = wdata_d;
                mwe_d   = we_d;
            end else begin
                gntf_d  = 1'b1;
                maddr_d = addr_f;
                mwe_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            store_q <= 1'b0;
            gntf_q  <= 1'b0;
            gntd_q  <= 1'b0;
            donef_q <= 1'b0;
            doned_q <= 1'b0;
            rdata_q <= '0;
            maddr_q <= '0;
            mdin_q  <= '0;
            mwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            store_q <= store_d;
            gntf_q  <= gntf_d;
            gntd_q  <= gntd_d;
            donef_q <= donef_d;
            doned_q <= doned_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
            mdin_q  <= mdin_d;
            mwe_q   <= mwe_d;
        end
    end

    assign gnt_f       = gntf_q;
    assign gnt_d       = gntd_q;
    assign done_f      = donef_q;
    assign done_d      = doned_q;
    assign rdata       = rdata_q;
    assign busy        = (state_q != S_IDLE);
    assign mem_addr    = maddr_q;
    assign mem_din     = mdin_q;
    assign mem_we      = mwe_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-timeline model of grants, dones
// and memory contents is checked against the DUT on every falling edge.
module tb_mem_port_arbiter;

    localparam int N = 2048;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        req_f = 1'b0;
    logic [15:0] addr_f = '0;
    logic        req_d = 1'b0;
    logic [15:0] addr_d = '0;
    logic [15:0] wdata_d = '0;
    logic        we_d = 1'b0;
    logic        gnt_f, gnt_d, done_f, done_d, busy, mem_we;
    logic [15:0] rdata, mem_addr, mem_din;
    logic [15:0] mem_q = '0;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .req_f(req_f), .addr_f(addr_f),
        .req_d(req_d), .addr_d(addr_d), .wdata_d(wdata_d), .we_d(we_d),
        .gnt_f(gnt_f), .gnt_d(gnt_d), .done_f(done_f), .done_d(done_d),
        .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_q(mem_q), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 Clock = ~Clock;

    // ---------------- RAM environment ----------------
    logic [15:0] ram [0:255];
    always @(posedge Clock) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_din;
        mem_q <= ram[mem_addr[7:0]];
    end

    function automatic logic [15:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return (i == 5) ? 16'hABCD : {b, ~b};
    endfunction

    // ---------------- timeline model ----------------
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        e_gf [N], e_gd [N], e_df [N], e_dd [N], e_we [N], e_busy [N];
    logic        s_rd_v [N], s_wr_v [N];
    logic [15:0] s_rd [N], s_wr_a [N], s_wr_v_data [N];
    logic [15:0] model_mem [0:255];
    logic [15:0] m_addr = '0, m_din = '0, m_rdata = '0;
    logic        m_prio_d = 1'b0;
    int          next_free = 0;
    int          g_who [$];
    int          g_cyc [$];
    int          we_cnt = 0;
    int          dd_cnt = 0;

    task automatic clear_from(input int c);
        for (int i = c; i < N; i++) begin
            e_gf[i] = 0; e_gd[i] = 0; e_df[i] = 0; e_dd[i] = 0;
            e_we[i] = 0; e_busy[i] = 0; s_rd_v[i] = 0; s_wr_v[i] = 0;
            s_rd[i] = '0; s_wr_a[i] = '0; s_wr_v_data[i] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = init_word(i);
            model_mem[i] = init_word(i);
        end
        clear_from(0);
    end

    always @(negedge Resetn) begin
        clear_from(cyc);
        m_addr = '0; m_din = '0; m_rdata = '0;
        m_prio_d = 1'b0;
        next_free = 0;
    end

    always @(posedge Clock) begin
        bit win;
        cyc = cyc + 1;
        if (Resetn && cyc + 2 < N) begin
            if (s_rd_v[cyc]) m_rdata = s_rd[cyc];
            if (s_wr_v[cyc]) model_mem[s_wr_a[cyc][7:0]] = s_wr_v_data[cyc];
            if (cyc >= next_free && (req_f || req_d)) begin
                win = req_d && (!req_f || m_prio_d);
                m_prio_d = !win;
                next_free = cyc + 2;
                e_busy[cyc] = 1; e_busy[cyc+1] = 1;
                if (win) begin
                    e_gd[cyc] = 1; e_dd[cyc+2] = 1;
                    m_addr = addr_d; m_din = wdata_d;
                    if (we_d) begin
                        e_we[cyc] = 1;
                        s_wr_v[cyc+1] = 1; s_wr_a[cyc+1] = addr_d; s_wr_v_data[cyc+1] = wdata_d;
                    end else begin
                        s_rd_v[cyc+2] = 1; s_rd[cyc+2] = model_mem[addr_d[7:0]];
                    end
                end else begin
                    e_gf[cyc] = 1; e_df[cyc+2] = 1;
                    m_addr = addr_f;
                    s_rd_v[cyc+2] = 1; s_rd[cyc+2] = model_mem[addr_f[7:0]];
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (cyc > 0 && cyc < N) begin
            if (!Resetn) begin
                chk("rst_gnt_f", {15'd0, gnt_f}, 16'd0);
                chk("rst_gnt_d", {15'd0, gnt_d}, 16'd0);
                chk("rst_done_f", {15'd0, done_f}, 16'd0);
                chk("rst_done_d", {15'd0, done_d}, 16'd0);
                chk("rst_busy", {15'd0, busy}, 16'd0);
                chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
                chk("rst_rdata", rdata, 16'd0);
                chk("rst_mem_addr", mem_addr, 16'd0);
                chk("rst_mem_din", mem_din, 16'd0);
            end else begin
                chk("gnt_f", {15'd0, gnt_f}, {15'd0, e_gf[cyc]});
                chk("gnt_d", {15'd0, gnt_d}, {15'd0, e_gd[cyc]});
                chk("done_f", {15'd0, done_f}, {15'd0, e_df[cyc]});
                chk("done_d", {15'd0, done_d}, {15'd0, e_dd[cyc]});
                chk("busy", {15'd0, busy}, {15'd0, e_busy[cyc]});
                chk("mem_we", {15'd0, mem_we}, {15'd0, e_we[cyc]});
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_din", mem_din, m_din);
                chk("rdata", rdata, m_rdata);
                if (gnt_f) begin g_who.push_back(0); g_cyc.push_back(cyc); end
                if (gnt_d) begin g_who.push_back(1); g_cyc.push_back(cyc); end
            end
            if (mem_we) we_cnt++;
            if (done_d) dd_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // sel: 0 gnt_f, 1 gnt_d, 2 done_f, 3 done_d, 4 any gnt
    task automatic wait_for(input int sel, input string nm, output int at);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            step();
            case (sel)
                0: hit = gnt_f;
                1: hit = gnt_d;
                2: hit = done_f;
                3: hit = done_d;
                default: hit = gnt_f | gnt_d;
            endcase
        end
        at = cyc;
        if (!hit) begin
            total++; bad++;
            $display("FAIL timeout_%s cyc=%0d actual=no_pulse required=pulse", nm, cyc);
        end
    endtask

    task automatic do_fetch(input logic [15:0] a, output int t_req, output int t_gnt,
                            output int t_done, output logic [15:0] rd);
        req_f = 1'b1; addr_f = a; t_req = cyc;
        wait_for(0, "gnt_f", t_gnt);
        req_f = 1'b0;
        wait_for(2, "done_f", t_done);
        rd = rdata;
    endtask

    task automatic do_ld_st(input logic we, input logic [15:0] a, input logic [15:0] wd,
                            output logic [15:0] rd);
        int t;
        req_d = 1'b1; we_d = we; addr_d = a; wdata_d = wd;
        wait_for(1, "gnt_d", t);
        req_d = 1'b0; we_d = 1'b0;
        wait_for(3, "done_d", t);
        rd = rdata;
    endtask

    task automatic do_reset(input int n);
        Resetn = 1'b0;
        repeat (n) step();
        Resetn = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t_req, t_gnt, t_done, t;
        logic [15:0] rd;

        // 1: reset with a pending store request
        req_d = 1'b1; we_d = 1'b1; addr_d = 16'h0033; wdata_d = 16'h7777;
        repeat (4) step();
        chk("reset_no_we", we_cnt[15:0], 16'd0);
        req_d = 1'b0; we_d = 1'b0;
        Resetn = 1'b1;
        step();

        // 2: lone fetch
        do_fetch(16'h0005, t_req, t_gnt, t_done, rd);
        chk("fetch_gnt_lat", 16'(t_gnt - t_req), 16'd1);
        chk("fetch_done_lat", 16'(t_done - t_req), 16'd3);
        chk("fetch_rdata", rd, 16'hABCD);
        chk("fetch_addr", mem_addr, 16'h0005);
        chk("fetch_no_done_d", dd_cnt[15:0], 16'd0);
        step();

        // 3: store then load same address
        we_cnt = 0;
        do_ld_st(1'b1, 16'h0010, 16'h1234, rd);
        do_ld_st(1'b0, 16'h0010, 16'h0000, rd);
        chk("store_we_cycles", we_cnt[15:0], 16'd1);
        chk("load_rdata", rd, 16'h1234);
        step();

        // 3b: store leaves rdata, loads from other addresses
        do_ld_st(1'b1, 16'h0011, 16'h5555, rd);
        chk("store_keeps_rdata", rd, 16'h1234);
        do_fetch(16'h0011, t_req, t_gnt, t_done, rd);
        chk("fetch_after_store", rd, 16'h5555);
        do_ld_st(1'b0, 16'h0042, 16'h0000, rd);
        chk("load_init_word", rd, 16'h42BD);

        // 4: contention after reset
        do_reset(2);
        g_who.delete(); g_cyc.delete();
        req_f = 1'b1; addr_f = 16'h0005;
        req_d = 1'b1; addr_d = 16'h0010; we_d = 1'b0;
        repeat (8) step();
        req_f = 1'b0; req_d = 1'b0;
        repeat (4) step();
        chk("cont_count", 16'(g_who.size()), 16'd4);
        if (g_who.size() == 4) begin
            chk("cont_order", 16'({g_who[0][0], g_who[1][0], g_who[2][0], g_who[3][0]}), 16'b0101);
            chk("cont_spacing", 16'(g_cyc[3] - g_cyc[0]), 16'd6);
        end

        // 5: reset during the ACCESS cycle of a store
        dd_cnt = 0; we_cnt = 0;
        req_d = 1'b1; we_d = 1'b1; addr_d = 16'h0020; wdata_d = 16'hBEEF;
        wait_for(1, "gnt_d_abort", t);
        req_d = 1'b0; we_d = 1'b0;
        #1 Resetn = 1'b0;
        #1 chk("abort_we_drop", {15'd0, mem_we}, 16'd0);
        chk("abort_state", {14'd0, dbg_state}, 16'd0);
        repeat (3) step();
        Resetn = 1'b1;
        step();
        chk("abort_no_done_d", dd_cnt[15:0], 16'd0);
        chk("abort_ram_kept", ram[8'h20], 16'h20DF);
        req_f = 1'b1; addr_f = 16'h0020;
        req_d = 1'b1; addr_d = 16'h0011; we_d = 1'b0;
        wait_for(4, "post_abort_gnt", t);
        chk("post_abort_f_first", {14'd0, gnt_f, gnt_d}, 16'b10);
        req_f = 1'b0;
        wait_for(1, "post_abort_gnt_d", t);
        req_d = 1'b0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
